// File: rtl/lfsr_range_sampler.sv
// Range-filtering sampler for an LFSR stream: accepts values below Range_Max into a FWFT FIFO
// and flags LFSR lock-up. Define LFSR_SAMPLER_STATS_EN to add the rej_count statistics output.
`timescale 1ns/1ps
module lfsr_range_sampler #(
  parameter int No_of_Bits  = 5,
  parameter int Range_Max   = 20,
  parameter int Fifo_Depth  = 4,
  parameter int Stuck_Limit = 8
) (
  input  logic                              clk,
  input  logic                              areset,
  input  logic                              enable,
  input  logic                              clear_err,
  input  logic [No_of_Bits-1:0]             rnd_in,
  output logic [No_of_Bits-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(Fifo_Depth+1)-1:0]   fifo_level,
`ifdef LFSR_SAMPLER_STATS_EN
  output logic [15:0]                       rej_count,
`endif
  output logic                              stuck_err
);

  localparam int AW = $clog2(Fifo_Depth);
  localparam int LW = $clog2(Fifo_Depth + 1);
  localparam int SW = $clog2(Stuck_Limit);
  // One extra bit so Range_Max == 2**No_of_Bits still compares correctly.
  localparam logic [No_of_Bits:0] RANGE_LIM = (No_of_Bits + 1)'(Range_Max);
  localparam logic [SW-1:0]       STUCK_TGT = SW'(Stuck_Limit - 2);
  localparam logic [LW-1:0]       FULL_LVL  = LW'(Fifo_Depth);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [No_of_Bits-1:0]   mem_q [Fifo_Depth];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [No_of_Bits-1:0]   last_q;
  logic [SW-1:0]           stuck_cnt_q, stuck_cnt_d;
  logic                    stuck_err_q, stuck_err_d;
  logic [Fifo_Depth-1:0]   wr_en;

  logic in_range;
  logic is_repeat;
  logic lockup;
  logic pop;
  logic push;

  assign in_range  = ({1'b0, rnd_in} < RANGE_LIM);
  assign is_repeat = (rnd_in == last_q);
  // The sample that completes the repeat run (or any zero) is the lock-up sample itself.
  assign lockup    = (state_q == S_RUN) &&
                     ((rnd_in == '0) || (is_repeat && (stuck_cnt_q == STUCK_TGT)));
  assign pop       = (level_q != '0) && out_ready;
  assign push      = (state_q == S_RUN) && !lockup && in_range &&
                     ((level_q != FULL_LVL) || pop);

  generate
    for (genvar gi = 0; gi < Fifo_Depth; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_q == AW'(gi));
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    stuck_err_d = stuck_err_q;
    stuck_cnt_d = '0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (lockup) begin
          state_d     = S_ERR;
          stuck_err_d = 1'b1;
        end else if (!enable) begin
          state_d = S_IDLE;
        end else if (is_repeat) begin
          stuck_cnt_d = stuck_cnt_q + 1'b1;
        end
      end
      S_ERR: begin
        if (clear_err) begin
          state_d     = enable ? S_RUN : S_IDLE;
          stuck_err_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      last_q      <= '0;
      stuck_cnt_q <= '0;
      stuck_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      last_q      <= rnd_in;
      stuck_cnt_q <= stuck_cnt_d;
      stuck_err_q <= stuck_err_d;
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < Fifo_Depth; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < Fifo_Depth; i++) begin
        if (wr_en[i]) mem_q[i] <= rnd_in;
      end
    end
  end

`ifdef LFSR_SAMPLER_STATS_EN
  logic [15:0] rej_q, rej_d;

  always_comb begin
    rej_d = rej_q;
    if ((state_q == S_ERR) && clear_err) begin
      rej_d = '0;
    end else if ((state_q == S_RUN) && !lockup && !in_range && (rej_q != 16'hFFFF)) begin
      rej_d = rej_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) rej_q <= '0;
    else         rej_q <= rej_d;
  end

  assign rej_count = rej_q;
`endif

  // Head is masked while empty so stale entries never leak onto the bus.
  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign stuck_err  = stuck_err_q;

endmodule
